// File: rtl/alu_issue.sv
// Decode/issue stage between instruction decode and the ALU: a two-entry (main + skid)
// buffer holding decoded operands. The writeback bypass is applied at capture and while held.
module alu_issue #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_JALR = 4'd10, ALU_COPY_B = 4'd11,
        ALU_AUIPC_ADD = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic        a_is_rs1;
        logic        b_is_rs2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        alu_op_e     op;
        logic        reg_write;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_EMPTY = '0;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // alt is funct7[5] (instr[30]); it only means SUB for register-register adds.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'd0: op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] rs1_val, input logic [31:0] rs2_val);
        entry_t      e;
        logic [31:0] imm_i, imm_s, imm_u, imm_j;
        logic        wr;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        e       = ENTRY_EMPTY;
        e.valid = 1'b1;
        e.instr = instr;
        e.pc    = pc;
        e.rs1   = instr[19:15];
        e.rs2   = instr[24:20];
        wr      = 1'b1;
        case (instr[6:0])
            OPC_OP:     begin e.a = rs1_val; e.b = rs2_val; e.a_is_rs1 = 1'b1; e.b_is_rs2 = 1'b1;
                              e.op = arith_op(instr[14:12], instr[30], 1'b1); end
            OPC_OP_IMM: begin e.a = rs1_val; e.b = imm_i; e.a_is_rs1 = 1'b1;
                              e.op = arith_op(instr[14:12], instr[30], 1'b0); end
            OPC_LUI:    begin e.b = imm_u; e.op = ALU_COPY_B; end
            OPC_AUIPC:  begin e.a = pc; e.b = imm_u; e.op = ALU_AUIPC_ADD; end
            OPC_JAL:    begin e.a = pc; e.b = imm_j; e.op = ALU_AUIPC_ADD; end
            OPC_JALR:   begin e.a = rs1_val; e.b = imm_i; e.a_is_rs1 = 1'b1; e.op = ALU_JALR; end
            OPC_LOAD:   begin e.a = rs1_val; e.b = imm_i; e.a_is_rs1 = 1'b1; e.op = ALU_ADD; end
            OPC_STORE:  begin e.a = rs1_val; e.b = imm_s; e.a_is_rs1 = 1'b1; e.op = ALU_ADD; wr = 1'b0; end
            OPC_BRANCH: begin e.a = rs1_val; e.b = rs2_val; e.a_is_rs1 = 1'b1; e.b_is_rs2 = 1'b1;
                              e.op = ALU_SUB; wr = 1'b0; end
            default:    begin e.illegal = 1'b1; wr = 1'b0; end
        endcase
        e.reg_write = wr && (instr[11:7] != 5'd0);
        return e;
    endfunction

    // Only register-sourced operands are refreshed; x0 is never bypassed.
    function automatic entry_t apply_fwd(input entry_t e, input logic f_valid,
                                         input logic [4:0] f_rd, input logic [31:0] f_data);
        entry_t r;
        r = e;
        if (f_valid && f_rd != 5'd0) begin
            if (e.a_is_rs1 && e.rs1 == f_rd) r.a = f_data;
            if (e.b_is_rs2 && e.rs2 == f_rd) r.b = f_data;
        end
        return r;
    endfunction

    entry_t      r_main, r_skid;
    logic        r_in_ready;
    entry_t      w_main_fwd, w_skid_fwd, w_new, w_main_nxt, w_skid_nxt;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic        w_accept, w_issue, w_fwd_hit;

    assign w_fwd_hit = fwd_valid && (fwd_rd != 5'd0);
    assign w_rs1_val = (w_fwd_hit && fwd_rd == in_instr[19:15]) ? fwd_data : rs1_data;
    assign w_rs2_val = (w_fwd_hit && fwd_rd == in_instr[24:20]) ? fwd_data : rs2_data;
    assign w_new      = decode(in_instr, in_pc, w_rs1_val, w_rs2_val);
    assign w_main_fwd = apply_fwd(r_main, fwd_valid, fwd_rd, fwd_data);
    assign w_skid_fwd = apply_fwd(r_skid, fwd_valid, fwd_rd, fwd_data);
    assign w_accept   = in_valid && r_in_ready;
    assign w_issue    = r_main.valid && out_ready;

    always_comb begin
        w_main_nxt = w_main_fwd;
        w_skid_nxt = w_skid_fwd;
        if (flush) begin
            w_main_nxt = ENTRY_EMPTY;
            w_skid_nxt = ENTRY_EMPTY;
        end else if (!r_main.valid) begin
            if (w_accept) w_main_nxt = w_new;
        end else if (w_issue) begin
            // A full skid means in_ready was low, so no accept competes with the move.
            if (r_skid.valid) begin
                w_main_nxt = w_skid_fwd;
                w_skid_nxt = ENTRY_EMPTY;
            end else if (w_accept) begin
                w_main_nxt = w_new;
            end else begin
                w_main_nxt = ENTRY_EMPTY;
            end
        end else if (w_accept) begin
            w_skid_nxt = w_new;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= ENTRY_EMPTY;
            r_skid     <= ENTRY_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= !w_skid_nxt.valid;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main.valid;

    always_comb begin
        operand_a     = 32'd0;
        operand_b     = 32'd0;
        alu_op        = ALU_ADD;
        funct3        = NOP_INSTR[14:12];
        funct7        = NOP_INSTR[31:25];
        out_rd        = NOP_INSTR[11:7];
        out_reg_write = 1'b0;
        out_pc        = 32'd0;
        out_instr     = NOP_INSTR;
        illegal       = 1'b0;
        if (r_main.valid) begin
            operand_a     = r_main.a;
            operand_b     = r_main.b;
            alu_op        = r_main.op;
            funct3        = r_main.instr[14:12];
            funct7        = r_main.instr[31:25];
            out_rd        = r_main.instr[11:7];
            out_reg_write = r_main.reg_write;
            out_pc        = r_main.pc;
            out_instr     = r_main.instr;
            illegal       = r_main.illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode per instruction class, bypass, skid buffering,
// flush and asynchronous reset, with hand-computed expectations.
module tb_alu_issue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] operand_a, operand_b;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] out_pc, out_instr;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_pc(out_pc), .out_instr(out_instr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_dec(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic rw);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".op"}, {28'd0, alu_op}, {28'd0, op});
        check({tag, ".a"}, operand_a, a);
        check({tag, ".b"}, operand_b, b);
        check({tag, ".rw"}, {31'd0, out_reg_write}, {31'd0, rw});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; fwd_valid = 1'b0; fwd_rd = 5'd0;
        fwd_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_instr", out_instr, NOP);
        check("rst.ops", operand_a | operand_b, 32'd0);
        check("rst.ctl", {alu_op, funct3, funct7, out_reg_write, illegal}, 32'd0);
        check("rst.out_pc", out_pc, 32'd0);
        rst = 1'b0;

        // ADDI x5, x1, -3
        send(32'hFFD0_8293, 32'h40, 32'd10, 32'd0);
        check_dec("addi", 4'd0, 32'd10, 32'hFFFF_FFFD, 1'b1);
        check("addi.rd", {27'd0, out_rd}, 32'd5);
        check("addi.pc", out_pc, 32'h40);

        // SUB x3, x1, x2 with rs2 bypassed at capture
        fwd_valid = 1'b1; fwd_rd = 5'd2; fwd_data = 32'd4;
        send(32'h4020_81B3, 32'h44, 32'd7, 32'd9);
        fwd_valid = 1'b0;
        check_dec("sub", 4'd1, 32'd7, 32'd4, 1'b1);
        check("sub.f7", {25'd0, funct7}, 32'h20);

        // ADDI x5, x0, 1 with a bypass to x0 that must be ignored
        fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'h99;
        send(32'h0010_0293, 32'h48, 32'h55, 32'd0);
        fwd_valid = 1'b0;
        check_dec("x0fwd", 4'd0, 32'h55, 32'd1, 1'b1);

        send(32'h1234_5237, 32'h4C, 32'h1, 32'h2);          // LUI x4, 0x12345
        check_dec("lui", 4'd11, 32'd0, 32'h1234_5000, 1'b1);
        send(32'h0000_1097, 32'h100, 32'h1, 32'h2);         // AUIPC x1, 1
        check_dec("auipc", 4'd12, 32'h100, 32'h1000, 1'b1);
        send(32'h0080_00EF, 32'h200, 32'h1, 32'h2);         // JAL x1, +8
        check_dec("jal", 4'd12, 32'h200, 32'd8, 1'b1);
        send(32'h0041_00E7, 32'h204, 32'h3000, 32'h2);      // JALR x1, 4(x2)
        check_dec("jalr", 4'd10, 32'h3000, 32'd4, 1'b1);
        send(32'h0020_A623, 32'h208, 32'h1000, 32'h77);     // SW x2, 12(x1)
        check_dec("sw", 4'd0, 32'h1000, 32'd12, 1'b0);
        check("sw.f3", {29'd0, funct3}, 32'd2);
        send(32'h4030_D293, 32'h20C, 32'h8000_0000, 32'h0); // SRAI x5, x1, 3
        check_dec("srai", 4'd7, 32'h8000_0000, 32'h403, 1'b1);
        check("srai.f3", {29'd0, funct3}, 32'd5);
        send(32'h0020_8063, 32'h210, 32'h11, 32'h22);       // BEQ x1, x2
        check_dec("beq", 4'd1, 32'h11, 32'h22, 1'b0);
        send(32'h0020_8033, 32'h214, 32'h11, 32'h22);       // ADD x0, x1, x2
        check_dec("add_x0", 4'd0, 32'h11, 32'h22, 1'b0);
        send(32'h0000_0FFF, 32'h218, 32'h5, 32'h6);         // opcode 1111111, rd 31
        check_dec("illegal", 4'd0, 32'd0, 32'd0, 1'b0);
        check("illegal.flag", {31'd0, illegal}, 32'd1);
        check("illegal.instr", out_instr, 32'h0000_0FFF);

        tick();
        check("drain.valid", {31'd0, out_valid}, 32'd0);
        check("drain.illegal", {31'd0, illegal}, 32'd0);
        check("drain.instr", out_instr, NOP);

        // Held entry ADDI x7, x6, 5 picks up a later bypass of x6
        out_ready = 1'b0;
        send(32'h0053_0393, 32'h300, 32'h11, 32'h0);
        check("hold.a0", operand_a, 32'h11);
        fwd_valid = 1'b1; fwd_rd = 5'd6; fwd_data = 32'hCAFE;
        tick();
        fwd_valid = 1'b0;
        check("hold.a1", operand_a, 32'hCAFE);
        check("hold.b1", operand_b, 32'd5);
        out_ready = 1'b1;
        tick();
        check("hold.drain", {31'd0, out_valid}, 32'd0);

        // Three back-to-back instructions against a stalled ALU
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093; rs1_data = 32'd0;
        tick();
        check("skid.in_ready1", {31'd0, in_ready}, 32'd1);
        in_instr = 32'h0020_0113;
        tick();
        check("skid.in_ready2", {31'd0, in_ready}, 32'd0);
        check("skid.main2", out_instr, 32'h0010_0093);
        in_instr = 32'h0030_0193;
        tick();
        check("skid.main3", out_instr, 32'h0010_0093);
        check("skid.in_ready3", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("skid.B", out_instr, 32'h0020_0113);
        check("skid.B_b", operand_b, 32'd2);
        check("skid.in_ready4", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("skid.C", out_instr, 32'h0030_0193);
        check("skid.C_rd", {27'd0, out_rd}, 32'd3);
        tick();
        check("skid.empty", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and a pending input
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093;
        tick();
        in_instr = 32'h0020_0113;
        tick();
        check("flush.full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h0030_0193;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush.none", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h0010_0093, 32'h400, 32'd0, 32'd0);
        check("mrst.pre", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mrst.valid", {31'd0, out_valid}, 32'd0);
        check("mrst.instr", out_instr, NOP);
        check("mrst.b", operand_b, 32'd0);
        check("mrst.pc", out_pc, 32'd0);
        in_valid = 1'b1;
        tick();
        check("mrst.hold", {31'd0, out_valid}, 32'd0);
        check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
